// File: rtl/control_sequencer.sv
// Ring-counter control sequencer for a SAP-1 style core.
// Steps through fetch (T1-T3) and execute (T4-T6), decodes the IR opcode
// and drives one-hot control strobes. HLT parks the machine until clr.
module control_sequencer #(
    parameter int SHORT_CYCLE = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [3:0]       op_code,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             mar_load,
    output logic             ram_out,
    output logic             ram_write,
    output logic             ir_load,
    output logic             ir_out,
    output logic             acc_load,
    output logic             acc_out,
    output logic             b_load,
    output logic             alu_out,
    output logic [2:0]       alu_op,
    output logic             flags_load,
    output logic             halted,
    output logic [5:0]       t_state,
    output logic [CNT_W-1:0] instr_count
);

    // One-hot T-states; HALT sits in its own bit so t_state reads 0 there.
    typedef enum logic [6:0] {
        ST_T1   = 7'b0000001,
        ST_T2   = 7'b0000010,
        ST_T3   = 7'b0000100,
        ST_T4   = 7'b0001000,
        ST_T5   = 7'b0010000,
        ST_T6   = 7'b0100000,
        ST_HALT = 7'b1000000
    } state_t;

    localparam logic [3:0] OP_LDA   = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_MOVI  = 4'b0010;
    localparam logic [3:0] OP_MOV   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_CMP   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_ORI   = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_XORI  = 4'b1011;
    localparam logic [3:0] OP_ADDI  = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_ANDI  = 4'b1110;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             is_mem_alu;
    logic             is_imm_alu;
    logic [2:0]       alu_fn;
    logic             short_t4;
    logic             short_t5;

    // Opcode classification and ALU function select.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        is_mem_alu = 1'b0;
        is_imm_alu = 1'b0;
        alu_fn     = ALU_ADD;
        case (op_code)
            OP_ADD:  begin is_mem_alu = 1'b1; alu_fn = ALU_ADD; end
            OP_SUB:  begin is_mem_alu = 1'b1; alu_fn = ALU_SUB; end
            OP_AND:  begin is_mem_alu = 1'b1; alu_fn = ALU_AND; end
            OP_CMP:  begin is_mem_alu = 1'b1; alu_fn = ALU_SUB; end
            OP_OR:   begin is_mem_alu = 1'b1; alu_fn = ALU_OR;  end
            OP_XOR:  begin is_mem_alu = 1'b1; alu_fn = ALU_XOR; end
            OP_ORI:  begin is_imm_alu = 1'b1; alu_fn = ALU_OR;  end
            OP_XORI: begin is_imm_alu = 1'b1; alu_fn = ALU_XOR; end
            OP_ADDI: begin is_imm_alu = 1'b1; alu_fn = ALU_ADD; end
            OP_SUBI: begin is_imm_alu = 1'b1; alu_fn = ALU_SUB; end
            OP_ANDI: begin is_imm_alu = 1'b1; alu_fn = ALU_AND; end
            default: ;
        endcase
    end

    // Early return to T1 when the remaining T-states would only idle.
    assign short_t4 = (SHORT_CYCLE != 0) && ((op_code == OP_MOVI) || (op_code == OP_MOV));
    assign short_t5 = (SHORT_CYCLE != 0) &&
                      ((op_code == OP_LDA) || (op_code == OP_STORE) || is_imm_alu);
    assign count_d  = count_q + CNT_W'(1);

    // Ring-counter sequencing, halt handling and retired-instruction count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (clr) begin
            state_q <= ST_T1;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_T1: if (run) state_q <= ST_T2;
                ST_T2: state_q <= ST_T3;
                ST_T3: state_q <= ST_T4;
                ST_T4: begin
                    if (op_code == OP_HLT) begin
                        state_q <= ST_HALT;
                    end else if (short_t4) begin
                        state_q <= ST_T1;
                        count_q <= count_d;
                    end else begin
                        state_q <= ST_T5;
                    end
                end
                ST_T5: begin
                    if (short_t5) begin
                        state_q <= ST_T1;
                        count_q <= count_d;
                    end else begin
                        state_q <= ST_T6;
                    end
                end
                ST_T6: begin
                    state_q <= ST_T1;
                    count_q <= count_d;
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_T1;  // recover from an illegal encoding
            endcase
        end
    end

    // Control strobes decoded from the current T-state and opcode.
    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        mar_load   = 1'b0;
        ram_out    = 1'b0;
        ram_write  = 1'b0;
        ir_load    = 1'b0;
        ir_out     = 1'b0;
        acc_load   = 1'b0;
        acc_out    = 1'b0;
        b_load     = 1'b0;
        alu_out    = 1'b0;
        alu_op     = ALU_ADD;
        flags_load = 1'b0;
        if (!clr) begin
            case (state_q)
                ST_T1: if (run) begin pc_out = 1'b1; mar_load = 1'b1; end
                ST_T2: pc_inc = 1'b1;
                ST_T3: begin ram_out = 1'b1; ir_load = 1'b1; end
                ST_T4: begin
                    if (op_code == OP_MOVI) begin
                        ir_out = 1'b1; acc_load = 1'b1;
                    end else if (op_code == OP_MOV) begin
                        acc_out = 1'b1; b_load = 1'b1;
                    end else if (is_imm_alu) begin
                        ir_out = 1'b1; b_load = 1'b1;
                    end else if (op_code != OP_HLT) begin
                        // LDA, STORE and memory ALU ops fetch their operand address.
                        ir_out = 1'b1; mar_load = 1'b1;
                    end
                end
                ST_T5: begin
                    if (op_code == OP_LDA) begin
                        ram_out = 1'b1; acc_load = 1'b1;
                    end else if (op_code == OP_STORE) begin
                        acc_out = 1'b1; ram_write = 1'b1;
                    end else if (is_mem_alu) begin
                        ram_out = 1'b1; b_load = 1'b1;
                    end else if (is_imm_alu) begin
                        alu_out = 1'b1; acc_load = 1'b1; flags_load = 1'b1; alu_op = alu_fn;
                    end
                end
                ST_T6: begin
                    if (is_mem_alu) begin
                        alu_out    = 1'b1;
                        flags_load = 1'b1;
                        alu_op     = alu_fn;
                        acc_load   = (op_code != OP_CMP);  // CMP only updates flags
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state     = state_q[5:0];
    assign halted      = (state_q == ST_HALT);
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: drives one stimulus stream into a
// SHORT_CYCLE=0 and a SHORT_CYCLE=1 instance and compares both every cycle
// against an independent T-state / instruction-length model.
module tb_control_sequencer;

    // Strobe bit positions in the packed strobe vector.
    localparam int PC_OUT = 11, PC_INC = 10, MAR_LD = 9, RAM_OUT = 8, RAM_WR = 7, IR_LD = 6;
    localparam int IR_OUT = 5, ACC_LD = 4, ACC_OUT = 3, B_LD = 2, ALU_OUT = 1, FLG_LD = 0;

    localparam logic [3:0] LDA = 4'h0, MOVI = 4'h2, ADD = 4'h4, CMP = 4'h7, HLT = 4'hF;

    typedef struct packed {
        logic [5:0]  t;
        logic [11:0] s;
        logic [2:0]  a;
        logic        h;
        logic [7:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr, run;
    logic [3:0]  op_code;
    logic [11:0] s0, s1;
    logic [2:0]  a0, a1;
    logic [5:0]  t0, t1;
    logic        h0, h1;
    logic [7:0]  c0, c1;

    exp_t        q0[$], q1[$];
    int          step_m[2];
    logic [7:0]  cnt_m[2];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    control_sequencer #(.SHORT_CYCLE(0), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .run(run), .op_code(op_code),
        .pc_out(s0[PC_OUT]), .pc_inc(s0[PC_INC]), .mar_load(s0[MAR_LD]),
        .ram_out(s0[RAM_OUT]), .ram_write(s0[RAM_WR]), .ir_load(s0[IR_LD]),
        .ir_out(s0[IR_OUT]), .acc_load(s0[ACC_LD]), .acc_out(s0[ACC_OUT]),
        .b_load(s0[B_LD]), .alu_out(s0[ALU_OUT]), .alu_op(a0),
        .flags_load(s0[FLG_LD]), .halted(h0), .t_state(t0), .instr_count(c0)
    );

    control_sequencer #(.SHORT_CYCLE(1), .CNT_W(8)) dut_sc (
        .clk(clk), .clr(clr), .run(run), .op_code(op_code),
        .pc_out(s1[PC_OUT]), .pc_inc(s1[PC_INC]), .mar_load(s1[MAR_LD]),
        .ram_out(s1[RAM_OUT]), .ram_write(s1[RAM_WR]), .ir_load(s1[IR_LD]),
        .ir_out(s1[IR_OUT]), .acc_load(s1[ACC_LD]), .acc_out(s1[ACC_OUT]),
        .b_load(s1[B_LD]), .alu_out(s1[ALU_OUT]), .alu_op(a1),
        .flags_load(s1[FLG_LD]), .halted(h1), .t_state(t1), .instr_count(c1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] op);
        return op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
    endfunction

    function automatic bit is_imm(input logic [3:0] op);
        return op inside {4'h9, 4'hB, 4'hC, 4'hD, 4'hE};
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            4'h4, 4'hC:       return 3'b000;
            4'h5, 4'h7, 4'hD: return 3'b001;
            4'h6, 4'hE:       return 3'b010;
            4'h8, 4'h9:       return 3'b011;
            4'hA, 4'hB:       return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    // Number of T-states a non-HLT instruction occupies.
    function automatic int instr_len(input logic [3:0] op, input bit sc);
        if (!sc) return 6;
        if (op == 4'h2 || op == 4'h3) return 4;
        if (op == 4'h0 || op == 4'h1 || is_imm(op)) return 5;
        return 6;
    endfunction

    function automatic logic [14:0] model_strobes(input int st, input logic [3:0] op,
                                                  input logic rn, input logic cl);
        logic [11:0] s;
        logic [2:0]  a;
        s = '0;
        a = '0;
        if (!cl) begin
            case (st)
                1: if (rn) begin s[PC_OUT] = 1'b1; s[MAR_LD] = 1'b1; end
                2: s[PC_INC] = 1'b1;
                3: begin s[RAM_OUT] = 1'b1; s[IR_LD] = 1'b1; end
                4: begin
                    if (op == 4'h2) begin s[IR_OUT] = 1'b1; s[ACC_LD] = 1'b1; end
                    else if (op == 4'h3) begin s[ACC_OUT] = 1'b1; s[B_LD] = 1'b1; end
                    else if (is_imm(op)) begin s[IR_OUT] = 1'b1; s[B_LD] = 1'b1; end
                    else if (op != 4'hF) begin s[IR_OUT] = 1'b1; s[MAR_LD] = 1'b1; end
                end
                5: begin
                    if (op == 4'h0) begin s[RAM_OUT] = 1'b1; s[ACC_LD] = 1'b1; end
                    else if (op == 4'h1) begin s[ACC_OUT] = 1'b1; s[RAM_WR] = 1'b1; end
                    else if (is_mem(op)) begin s[RAM_OUT] = 1'b1; s[B_LD] = 1'b1; end
                    else if (is_imm(op)) begin
                        s[ALU_OUT] = 1'b1; s[ACC_LD] = 1'b1; s[FLG_LD] = 1'b1; a = alu_of(op);
                    end
                end
                6: if (is_mem(op)) begin
                    s[ALU_OUT] = 1'b1; s[FLG_LD] = 1'b1; s[ACC_LD] = (op != 4'h7); a = alu_of(op);
                end
                default: ;
            endcase
        end
        return {s, a};
    endfunction

    function automatic exp_t model_exp(input int d);
        exp_t e;
        e.t = (step_m[d] == 0) ? 6'd0 : 6'(1 << (step_m[d] - 1));
        e.h = (step_m[d] == 0);
        e.c = cnt_m[d];
        {e.s, e.a} = model_strobes(step_m[d], op_code, run, clr);
        return e;
    endfunction

    // Model state update at the clock edge; step 0 is HALT.
    task automatic model_step(input int d, input bit sc);
        if (clr) begin
            step_m[d] = 1;
            cnt_m[d]  = 8'd0;
        end else if (step_m[d] == 0) begin
            step_m[d] = 0;
        end else if (step_m[d] == 1) begin
            step_m[d] = run ? 2 : 1;
        end else if (step_m[d] == 4 && op_code == 4'hF) begin
            step_m[d] = 0;
        end else if (step_m[d] == instr_len(op_code, sc)) begin
            step_m[d] = 1;
            cnt_m[d]  = cnt_m[d] + 8'd1;
        end else begin
            step_m[d] = step_m[d] + 1;
        end
    endtask

    task automatic compare(input int d);
        exp_t e, g;
        if (d == 0) begin
            e = q0.pop_front();
            g = {t0, s0, a0, h0, c0};
        end else begin
            e = q1.pop_front();
            g = {t1, s1, a1, h1, c1};
        end
        check($sformatf("d%0d t_state", d), 32'(g.t), 32'(e.t));
        check($sformatf("d%0d strobes", d), 32'(g.s), 32'(e.s));
        check($sformatf("d%0d alu_op", d), 32'(g.a), 32'(e.a));
        check($sformatf("d%0d halted", d), 32'(g.h), 32'(e.h));
        check($sformatf("d%0d instr_count", d), 32'(g.c), 32'(e.c));
        check($sformatf("d%0d bus_drivers", d),
              32'($countones({g.s[PC_OUT], g.s[RAM_OUT], g.s[IR_OUT], g.s[ACC_OUT], g.s[ALU_OUT]}) <= 1),
              32'd1);
    endtask

    // One clock: drive inputs, record expectations, sample at negedge, advance model.
    task automatic cyc(input logic c, input logic r, input logic [3:0] op);
        clr     = c;
        run     = r;
        op_code = op;
        q0.push_back(model_exp(0));
        q1.push_back(model_exp(1));
        @(negedge clk);
        compare(0);
        compare(1);
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
    endtask

    initial begin
        clr     = 1'b1;
        run     = 1'b0;
        op_code = LDA;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            step_m[d] = 1;
            cnt_m[d]  = 8'd0;
        end

        // LDA after a two-cycle reset
        cyc(1'b1, 1'b0, LDA);
        cyc(1'b1, 1'b0, LDA);
        repeat (7) cyc(1'b0, 1'b1, LDA);

        // CMP: flags only, no ACC load
        cyc(1'b1, 1'b0, CMP);
        repeat (13) cyc(1'b0, 1'b1, CMP);

        // MOVI long run: both counters wrap past 8'hFF
        cyc(1'b1, 1'b0, MOVI);
        repeat (257 * 6) cyc(1'b0, 1'b1, MOVI);

        // Every non-HLT opcode for one full instruction
        for (int o = 0; o < 15; o++) begin
            cyc(1'b1, 1'b0, o[3:0]);
            repeat (7) cyc(1'b0, 1'b1, o[3:0]);
        end

        // HLT: parked with run toggling, then cleared
        cyc(1'b1, 1'b0, HLT);
        repeat (4) cyc(1'b0, 1'b1, HLT);
        repeat (20) cyc(1'b0, 1'($urandom_range(0, 1)), HLT);
        cyc(1'b1, 1'b1, HLT);
        repeat (2) cyc(1'b0, 1'b0, LDA);

        // run=0 stalls in T1; dropping run after T1 does not stop the instruction
        cyc(1'b1, 1'b0, ADD);
        repeat (5) cyc(1'b0, 1'b0, ADD);
        repeat (2) cyc(1'b0, 1'b1, ADD);
        repeat (6) cyc(1'b0, 1'b0, ADD);

        // clr during T5 of ADD abandons the instruction
        cyc(1'b1, 1'b0, ADD);
        repeat (4) cyc(1'b0, 1'b1, ADD);
        cyc(1'b1, 1'b1, ADD);
        repeat (3) cyc(1'b0, 1'b0, ADD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
